// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers; TxD_start one cycle after a granted request.
// Holds off while TxD_busy is high; optional packet lock via `define UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GUARD_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 TxD_start,
  output logic [7:0]           TxD_data,
  input  logic                 TxD_busy,
  output logic                 arb_idle
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, GUARD} stateT;

  stateT          state;
  logic [IW-1:0]  rrPtr;
  logic [IW-1:0]  ownIdx;
  logic [IW-1:0]  winIdx;
  logic           winVld;
  logic [7:0]     guardCnt;

`ifdef UART_ARB_LOCK_EN
  logic           lockVld;
  logic [IW-1:0]  lockIdx;
`else
  logic           unusedLock;
  assign unusedLock = ^req_lock;
`endif

  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] k);
    if (int'(k) == NUM_REQ - 1) return '0;
    return k + IW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [IW-1:0] k);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    return oh;
  endfunction

  // Descending scan so the last hit is the first requester at or after rrPtr.
  always_comb begin
    winVld = 1'b0;
    winIdx = rrPtr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rrPtr) + i) % NUM_REQ]) begin
        winVld = 1'b1;
        winIdx = IW'((int'(rrPtr) + i) % NUM_REQ);
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (lockVld && req[lockIdx]) begin
      winVld = 1'b1;
      winIdx = lockIdx;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      ownIdx    <= '0;
      guardCnt  <= '0;
      ack       <= '0;
      grant     <= '0;
      TxD_start <= 1'b0;
      TxD_data  <= 8'h00;
      arb_idle  <= 1'b1;
`ifdef UART_ARB_LOCK_EN
      lockVld   <= 1'b0;
      lockIdx   <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
`ifdef UART_ARB_LOCK_EN
          if (lockVld && !req[lockIdx]) begin
            lockVld <= 1'b0;
            grant   <= '0;
          end
`endif
          if (winVld && !TxD_busy) begin
            state     <= START;
            ownIdx    <= winIdx;
            grant     <= oneHot(winIdx);
            TxD_data  <= req_data[8*int'(winIdx) +: 8];
            TxD_start <= 1'b1;
            arb_idle  <= 1'b0;
          end else begin
            arb_idle  <= ~|req;
          end
        end
        START: begin
          if (TxD_busy) begin
            TxD_start <= 1'b0;
            ack       <= oneHot(ownIdx);
            state     <= WAIT;
`ifdef UART_ARB_LOCK_EN
            if (req_lock[ownIdx]) begin
              lockVld <= 1'b1;
              lockIdx <= ownIdx;
            end else begin
              lockVld <= 1'b0;
              rrPtr   <= nextIdx(ownIdx);
            end
`else
            rrPtr     <= nextIdx(ownIdx);
`endif
          end
        end
        WAIT: begin
          if (!TxD_busy) begin
            state    <= (GUARD_CYCLES > 0) ? GUARD : IDLE;
            guardCnt <= '0;
            arb_idle <= (GUARD_CYCLES == 0) && !(|req);
`ifdef UART_ARB_LOCK_EN
            if (!lockVld) grant <= '0;
`else
            grant    <= '0;
`endif
          end
        end
        GUARD: begin
          if (guardCnt == 8'(GUARD_CYCLES - 1)) begin
            state    <= IDLE;
            arb_idle <= ~|req;
          end else begin
            guardCnt <= guardCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiters (guard 0 and guard 5) driven by a hand-stepped transmitter busy line.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req, reqLock;
  logic [8*N-1:0] reqData;
  logic           busy, busyG;

  logic [N-1:0]   ack, grant, ackG, grantG;
  logic           txStart, txStartG, arbIdle, arbIdleG;
  logic [7:0]     txData, txDataG;

  int nChecks = 0;
  int nFail   = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(reqData), .req_lock(reqLock),
    .ack(ack), .grant(grant), .TxD_start(txStart), .TxD_data(txData),
    .TxD_busy(busy), .arb_idle(arbIdle)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(5)) dutG (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(reqData), .req_lock(reqLock),
    .ack(ackG), .grant(grantG), .TxD_start(txStartG), .TxD_data(txDataG),
    .TxD_busy(busyG), .arb_idle(arbIdleG)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    busy  = 1'b0;
    busyG = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for TxD_start, plays the transmitter for busyLen cycles, checks grant/data/ack and start-to-start latency.
  task automatic serveByte(input bit g, input int expIdx, input logic [7:0] expDat,
                           input int expLat, input int busyLen);
    int waited = 0;
    while (((g ? txStartG : txStart) !== 1'b1) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("start_seen", g ? txStartG : txStart, 1);
    if (waited >= 100) return;
    if (expLat >= 0) chk("latency", waited, expLat);
    chk("grant", g ? grantG : grant, 32'd1 << expIdx);
    chk("data", g ? txDataG : txData, expDat);
    if (g) busyG = 1'b1; else busy = 1'b1;
    @(negedge clk);
    chk("ack_on_busy", g ? ackG : ack, 32'd1 << expIdx);
    chk("start_drop", g ? txStartG : txStart, 0);
    @(negedge clk);
    chk("ack_single", g ? ackG : ack, 0);
    repeat (busyLen - 2) @(negedge clk);
    chk("no_restart_busy", g ? txStartG : txStart, 0);
    if (g) busyG = 1'b0; else busy = 1'b0;
  endtask

  initial begin
    int expOrd[5];
    int twos;
    req     = '0;
    reqLock = '0;
    reqData = {8'hA3, 8'hA2, 8'hA1, 8'h0F};
    @(negedge clk);

    // Reset state
    doReset();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_start", txStart, 0);
    chk("rst_data", txData, 8'h00);
    chk("rst_ack", ack, 0);
    chk("rst_idle", arbIdle, 1);

    // Single requester
    req = 4'b0001;
    serveByte(0, 0, 8'h0F, 1, 6);
    req = '0;
    repeat (4) @(negedge clk);
    chk("single_no_second", txStart, 0);
    chk("single_idle", arbIdle, 1);
    chk("single_grant_clr", grant, 0);

    // All requesting: strict rotation, GUARD_CYCLES=0 gives 2-cycle gap
    doReset();
    reqData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b1111;
    for (int k = 0; k < 6; k++)
      serveByte(0, k % 4, 8'hA0 + 8'(k % 4), (k == 0) ? 1 : 2, 5);
    req = '0;

    // Reset mid-WAIT while transmitter stays busy
    doReset();
    req = 4'b0001;
    @(negedge clk);
    chk("mid_start", txStart, 1);
    busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_start", txStart, 0);
    chk("async_rst_grant", grant, 0);
    chk("async_rst_ack", ack, 0);
    chk("async_rst_idle", arbIdle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_hold_start", txStart, 0);
    chk("busy_hold_grant", grant, 0);
    chk("busy_hold_idle", arbIdle, 0);
    busy = 1'b0;
    serveByte(0, 0, 8'hA0, 1, 4);
    req = '0;

    // Packet lock vs plain rotation
`ifdef UART_ARB_LOCK_EN
    expOrd = '{2, 2, 2, 2, 0};
`else
    expOrd = '{2, 0, 2, 0, 2};
`endif
    doReset();
    reqData = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req = 4'b0100;
    twos = 0;
    for (int b = 0; b < 5; b++) begin
      reqLock = (twos < 3) ? 4'b0100 : 4'b0000;
      serveByte(0, expOrd[b], 8'hD0 + 8'(expOrd[b]), -1, 4);
      if (expOrd[b] == 2) twos++;
      req = 4'b0101;
    end
    req = '0;
    reqLock = '0;

    // Guard cycles: busy fall to next start is GUARD_CYCLES+2
    doReset();
    reqData = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'b0001;
    serveByte(1, 0, 8'hA0, 1, 5);
    serveByte(1, 0, 8'hA0, 7, 5);
    req = '0;
    repeat (10) @(negedge clk);
    chk("guard_idle", arbIdleG, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end
endmodule
